// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// bcd_stopwatch_ctrl_pkg: shared state encoding, BCD constants and digit increment helper
package bcd_stopwatch_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    return (d == BCD_MAX) ? '0 : d + 4'd1;
  endfunction
endpackage

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// bcd_digit: one BCD digit; CK/AR clock and async low reset, CE count enable, SCLR sync clear, Q digit, CO = CE & (Q==9)
module bcd_digit
  import bcd_stopwatch_ctrl_pkg::*;
(
  input  logic               CK,
  input  logic               AR,
  input  logic               CE,
  input  logic               SCLR,
  output logic [DIGIT_W-1:0] Q,
  output logic               CO
);
  always_ff @(posedge CK or negedge AR)
    if (!AR) Q <= '0;
    else if (SCLR) Q <= '0;
    else if (CE) Q <= bcd_inc(Q);
  assign CO = CE & (Q == BCD_MAX);
endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: start/stop/clear BCD stopwatch; in CK AR START STOP CLR LAP LIMIT_EN LIMIT, out Q RUN DONE OVF LAPPED
module bcd_stopwatch_ctrl
  import bcd_stopwatch_ctrl_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  CK,
  input  logic                  AR,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  CLR,
  input  logic                  LAP,
  input  logic                  LIMIT_EN,
  input  logic [4*DIGITS-1:0]   LIMIT,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  RUN,
  output logic                  DONE,
  output logic                  OVF,
  output logic                  LAPPED
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  state_t state, state_d;
  logic [PW-1:0] pre;
  logic [4*DIGITS-1:0] digits, nxt, lap_q;
  logic [DIGITS:0] ce;
  logic tick, hit, hold;
  assign tick = (state == ST_RUN) && (pre == PMAX);
  assign ce[0] = tick;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .CK   (CK),
      .AR   (AR),
      .CE   (ce[i]),
      .SCLR (CLR),
      .Q    (digits[4*i +: 4]),
      .CO   (ce[i+1])
    );
    assign nxt[4*i +: 4] = ce[i] ? bcd_inc(digits[4*i +: 4]) : digits[4*i +: 4];
  end
  assign hit = tick && LIMIT_EN && (nxt == LIMIT);
  always_comb begin
    state_d = state;
    if (CLR) state_d = ST_IDLE;
    else if (state == ST_RUN) state_d = hit ? ST_DONE : STOP ? ST_PAUSE : ST_RUN;
    else if (state != ST_DONE) state_d = (START && !STOP) ? ST_RUN : state;
  end
  always_ff @(posedge CK or negedge AR)
    if (!AR) state <= ST_IDLE;
    else state <= state_d;
  always_ff @(posedge CK or negedge AR)
    if (!AR) begin
      pre   <= '0;
      OVF   <= 1'b0;
      hold  <= 1'b0;
      lap_q <= '0;
    end else if (CLR) begin
      pre  <= '0;
      OVF  <= 1'b0;
      hold <= 1'b0;
    end else begin
      if (state == ST_RUN) pre <= tick ? '0 : pre + 1'b1;
      if (ce[DIGITS]) OVF <= 1'b1;
      if (LAP && (state == ST_RUN || state == ST_PAUSE)) begin
        hold <= !hold;
        if (!hold) lap_q <= nxt;
      end
    end
  assign Q      = hold ? lap_q : digits;
  assign RUN    = state == ST_RUN;
  assign DONE   = state == ST_DONE;
  assign LAPPED = hold;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: randomized and directed scoreboard bench against an arithmetic stopwatch model
module tb_bcd_stopwatch_ctrl;
  localparam int D = 2;
  localparam int P = 2;
  localparam int MOD = 100;
  localparam int IDLE = 0, RUNS = 1, PAUSE = 2, DONES = 3;
  typedef struct packed {
    logic [4*D-1:0] q;
    logic run, done, ovf, lapped;
  } exp_t;
  logic CK = 0, AR = 0, start = 0, stop = 0, clr = 0, lap = 0, len = 0;
  logic [4*D-1:0] lim = '0, Q;
  logic RUN, DONE, OVF, LAPPED;
  int total = 0, bad = 0;
  int m_st = IDLE, m_cnt = 0, m_pre = 0, m_lap = 0;
  bit m_ovf = 0, m_hold = 0;
  exp_t sb[$];
  bcd_stopwatch_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
    .CK(CK), .AR(AR), .START(start), .STOP(stop), .CLR(clr), .LAP(lap),
    .LIMIT_EN(len), .LIMIT(lim), .Q(Q), .RUN(RUN), .DONE(DONE), .OVF(OVF), .LAPPED(LAPPED)
  );
  always #5 CK = ~CK;
  function automatic logic [4*D-1:0] to_bcd(input int n);
    logic [4*D-1:0] v;
    for (int i = 0; i < D; i++) begin
      v[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return v;
  endfunction
  function automatic bit at_tick();
    return m_st == RUNS && m_pre == P - 1;
  endfunction
  task automatic model_step();
    int ncnt;
    bit tk, hit;
    exp_t e;
    if (clr) begin
      m_st = IDLE; m_cnt = 0; m_pre = 0; m_ovf = 0; m_hold = 0;
    end else begin
      tk = at_tick();
      ncnt = tk ? (m_cnt + 1) % MOD : m_cnt;
      if (tk && m_cnt == MOD - 1) m_ovf = 1;
      if (m_st == RUNS) m_pre = (m_pre + 1) % P;
      hit = tk && len && (to_bcd(ncnt) == lim);
      if (lap && (m_st == RUNS || m_st == PAUSE)) begin
        if (m_hold) m_hold = 0;
        else begin
          m_hold = 1;
          m_lap = ncnt;
        end
      end
      if (m_st == RUNS) m_st = hit ? DONES : stop ? PAUSE : RUNS;
      else if (m_st != DONES && start && !stop) m_st = RUNS;
      m_cnt = ncnt;
    end
    e.q = to_bcd(m_hold ? m_lap : m_cnt);
    e.run = m_st == RUNS;
    e.done = m_st == DONES;
    e.ovf = m_ovf;
    e.lapped = m_hold;
    sb.push_back(e);
  endtask
  task automatic step(input bit s, input bit p, input bit c, input bit l);
    @(negedge CK);
    start = s; stop = p; clr = c; lap = l;
    @(posedge CK);
    model_step();
  endtask
  task automatic chk_zero(input string name);
    total++;
    if ({Q, RUN, DONE, OVF, LAPPED} != '0) begin
      bad++;
      $display("FAIL %s: got q=%h run=%b done=%b ovf=%b lapped=%b, want all zero", name, Q, RUN, DONE, OVF, LAPPED);
    end
  endtask
  task automatic async_reset();
    @(negedge CK);
    start = 0; stop = 0; clr = 0; lap = 0;
    #2 AR = 0;
    #1 chk_zero("async_rst");
    m_st = IDLE; m_cnt = 0; m_pre = 0; m_lap = 0; m_ovf = 0; m_hold = 0;
    #1 AR = 1;
    @(posedge CK);
    model_step();
  endtask
  initial begin
    exp_t e, g;
    forever begin
      @(negedge CK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = '{Q, RUN, DONE, OVF, LAPPED};
        total++;
        if (g != e) begin
          bad++;
          $display("FAIL outputs @%0t: got q=%h run=%b done=%b ovf=%b lapped=%b, want q=%h run=%b done=%b ovf=%b lapped=%b",
                   $time, g.q, g.run, g.done, g.ovf, g.lapped, e.q, e.run, e.done, e.ovf, e.lapped);
        end
      end
    end
  end
  initial begin
    @(negedge CK);
    #1 chk_zero("por");
    #1 AR = 1;
    @(posedge CK);
    model_step();
    step(1, 0, 0, 0);
    repeat (205) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    async_reset();
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    lim = 8'h25; len = 1;
    step(1, 0, 0, 0);
    repeat (60) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    len = 0;
    step(1, 0, 0, 0);
    while (m_cnt != 12) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (10) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    while (!at_tick()) step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    while (!at_tick()) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 30) == 0) begin
        for (int i = 0; i < D; i++) lim[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        len = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 400) == 0) async_reset();
      else step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0);
    end
    @(negedge CK);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
